// File: rtl/trap_ctrl_if.sv
// Commit, interrupt, CSR-state and trap/redirect signals exchanged between the
// pipeline (master) and the trap controller (slave).
interface trap_ctrl_if;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_next_pc;
  logic        commit_exc_valid;
  logic [5:0]  commit_exc_code;
  logic        commit_mret;

  logic        irq_ext;
  logic        irq_timer;
  logic        irq_sw;

  logic        mstatus_mie;
  logic [63:0] mie;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [1:0]  pmode;

  logic        trap_valid;
  logic [5:0]  trap_code;
  logic        is_exception;
  logic [63:0] trap_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic        stall_commit;

  modport master (
    output commit_valid, commit_pc, commit_next_pc, commit_exc_valid,
           commit_exc_code, commit_mret, irq_ext, irq_timer, irq_sw,
           mstatus_mie, mie, mtvec, mepc, pmode,
    input  trap_valid, trap_code, is_exception, trap_pc,
           redirect_valid, redirect_pc, flush, stall_commit
  );

  modport slave (
    input  commit_valid, commit_pc, commit_next_pc, commit_exc_valid,
           commit_exc_code, commit_mret, irq_ext, irq_timer, irq_sw,
           mstatus_mie, mie, mtvec, mepc, pmode,
    output trap_valid, trap_code, is_exception, trap_pc,
           redirect_valid, redirect_pc, flush, stall_commit
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap controller: takes exceptions, interrupts and mret at commit boundaries,
// emits a one-cycle trap record, then redirects and flushes the front end.
module trap_ctrl (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TRAP     = 2'd1;
  localparam logic [1:0] ST_WAIT     = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  logic [1:0]  state;
  logic [2:0]  sync_meta;   // {ext, timer, sw}
  logic [2:0]  pend;        // {ext, timer, sw}
  logic [5:0]  rec_code;
  logic        rec_exc;
  logic [63:0] rec_pc;
  logic [63:0] redir_pc;

  logic        int_en;
  logic        cand_ext;
  logic        cand_tmr;
  logic        cand_sw;
  logic        any_irq;
  logic [5:0]  irq_code;
  logic [63:0] base;
  logic [63:0] vec_pc;

  // NOTE: all state, including the latched record, is cleared by the async
  // reset so no stale trap can resume after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      pend      <= '0;
    end else begin
      sync_meta <= {bus.irq_ext, bus.irq_timer, bus.irq_sw};
      pend      <= sync_meta;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int_en   = (bus.pmode != 2'd3) | bus.mstatus_mie;
    cand_ext = pend[2] & bus.mie[11] & int_en;
    cand_tmr = pend[1] & bus.mie[7]  & int_en;
    cand_sw  = pend[0] & bus.mie[3]  & int_en;
    any_irq  = cand_ext | cand_sw | cand_tmr;
    irq_code = 6'd7;
    if (cand_ext)     irq_code = 6'd11;
    else if (cand_sw) irq_code = 6'd3;
    base   = {bus.mtvec[63:2], 2'b00};
    vec_pc = base;
    if (bus.mtvec[1:0] == 2'b01 && !rec_exc) vec_pc = base + {56'd0, rec_code, 2'b00};
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rec_code <= '0;
      rec_exc  <= 1'b0;
      rec_pc   <= '0;
      redir_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.commit_valid) begin
            if (bus.commit_exc_valid) begin
              state    <= ST_TRAP;
              rec_code <= bus.commit_exc_code;
              rec_exc  <= 1'b1;
              rec_pc   <= bus.commit_pc;
            end else if (any_irq) begin
              state    <= ST_TRAP;
              rec_code <= irq_code;
              rec_exc  <= 1'b0;
              rec_pc   <= bus.commit_next_pc;
            end else if (bus.commit_mret) begin
              state    <= ST_REDIRECT;
              redir_pc <= bus.mepc;
            end
          end
        end
        ST_TRAP: state <= ST_WAIT;
        ST_WAIT: begin
          redir_pc <= vec_pc;
          state    <= ST_REDIRECT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset drops them without a clock.
  assign bus.trap_valid     = (state == ST_TRAP);
  assign bus.redirect_valid = (state == ST_REDIRECT);
  assign bus.flush          = (state == ST_REDIRECT);
  assign bus.stall_commit   = (state != ST_IDLE);
  assign bus.trap_code      = rec_code;
  assign bus.is_exception   = rec_exc;
  assign bus.trap_pc        = rec_pc;
  assign bus.redirect_pc    = redir_pc;

  logic unused_mie;
  assign unused_mie = ^{bus.mie[63:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of commit scenarios plus
// hand-written sequences for synchronizer latency, ignored commits and reset.
module tb_trap_ctrl;

  logic clk;
  logic rst;
  trap_ctrl_if bus ();

  trap_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] M_EXT = 64'h800;
  localparam logic [63:0] M_TMR = 64'h80;
  localparam logic [63:0] M_SW  = 64'h8;
  localparam logic [2:0]  I_EXT = 3'b100;
  localparam logic [2:0]  I_TMR = 3'b010;
  localparam logic [2:0]  I_SW  = 3'b001;

  // kind: 0 = nothing taken, 1 = trap sequence, 2 = mret redirect
  typedef struct {
    logic [2:0]  irq;
    logic [63:0] mie;
    logic        mmie;
    logic [1:0]  pmode;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        exc;
    logic [5:0]  exc_code;
    logic        mret;
    logic [63:0] pc;
    logic [63:0] npc;
    int          kind;
    logic [5:0]  code;
    logic        isx;
    logic [63:0] tpc;
    logic [63:0] rpc;
  } vec_t;

  function automatic vec_t mk(logic [2:0] irq, logic [63:0] mie, logic mmie, logic [1:0] pmode,
                              logic [63:0] mtvec, logic [63:0] mepc, logic exc, logic [5:0] exc_code,
                              logic mret, logic [63:0] pc, logic [63:0] npc, int kind,
                              logic [5:0] code, logic isx, logic [63:0] tpc, logic [63:0] rpc);
    vec_t v;
    v.irq = irq; v.mie = mie; v.mmie = mmie; v.pmode = pmode; v.mtvec = mtvec; v.mepc = mepc;
    v.exc = exc; v.exc_code = exc_code; v.mret = mret; v.pc = pc; v.npc = npc; v.kind = kind;
    v.code = code; v.isx = isx; v.tpc = tpc; v.rpc = rpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    bus.commit_valid     = 1'b0;
    bus.commit_exc_valid = 1'b0;
    bus.commit_exc_code  = '0;
    bus.commit_mret      = 1'b0;
  endtask

  task automatic set_irq(input logic [2:0] irq);
    bus.irq_ext   = irq[2];
    bus.irq_timer = irq[1];
    bus.irq_sw    = irq[0];
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bus.mie = v.mie; bus.mstatus_mie = v.mmie; bus.pmode = v.pmode;
    bus.mtvec = v.mtvec; bus.mepc = v.mepc;
    set_irq(v.irq);
    repeat (3) tick();
    bus.commit_valid = 1'b1; bus.commit_exc_valid = v.exc; bus.commit_exc_code = v.exc_code;
    bus.commit_mret = v.mret; bus.commit_pc = v.pc; bus.commit_next_pc = v.npc;
    tick();
    clear_commit();
    if (v.kind == 1) begin
      check({tag, "_trap_valid"}, 64'(bus.trap_valid), 64'd1);
      check({tag, "_code"}, 64'(bus.trap_code), 64'(v.code));
      check({tag, "_is_exc"}, 64'(bus.is_exception), 64'(v.isx));
      check({tag, "_trap_pc"}, bus.trap_pc, v.tpc);
      check({tag, "_stall_trap"}, 64'(bus.stall_commit), 64'd1);
      tick();
      set_irq(3'b000);
      check({tag, "_wait"}, 64'({bus.trap_valid, bus.redirect_valid, bus.stall_commit}), 64'b001);
      tick();
      check({tag, "_redir"}, 64'({bus.redirect_valid, bus.flush, bus.trap_valid}), 64'b110);
      check({tag, "_redir_pc"}, bus.redirect_pc, v.rpc);
      check({tag, "_code_stable"}, 64'(bus.trap_code), 64'(v.code));
      tick();
      check({tag, "_idle"}, 64'({bus.redirect_valid, bus.flush, bus.stall_commit}), 64'b000);
    end else if (v.kind == 2) begin
      check({tag, "_mret_redir"}, 64'({bus.redirect_valid, bus.flush, bus.trap_valid}), 64'b110);
      check({tag, "_mret_pc"}, bus.redirect_pc, v.rpc);
      tick();
      check({tag, "_mret_idle"}, 64'({bus.redirect_valid, bus.trap_valid, bus.stall_commit}), 64'b000);
    end else begin
      check({tag, "_no_trap"}, 64'({bus.trap_valid, bus.redirect_valid, bus.stall_commit}), 64'b000);
      tick();
      check({tag, "_no_trap2"}, 64'({bus.trap_valid, bus.redirect_valid, bus.stall_commit}), 64'b000);
    end
    set_irq(3'b000);
    repeat (3) tick();
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.trap_valid, bus.is_exception, bus.redirect_valid, bus.flush,
            bus.stall_commit, bus.trap_code} | bus.trap_pc | bus.redirect_pc;
  endfunction

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk(3'b000, 64'd0, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b1, 6'd2, 1'b0,
                  64'h8000_0010, 64'h8000_0014, 1, 6'd2, 1'b1, 64'h8000_0010, 64'h8000_1000);
    vecs[1]  = mk(I_TMR, M_TMR, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0100, 64'h8000_0104, 1, 6'd7, 1'b0, 64'h8000_0104, 64'h8000_101C);
    vecs[2]  = mk(I_EXT | I_SW, M_EXT | M_SW, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b1, 6'd8, 1'b0,
                  64'h8000_0020, 64'h8000_0024, 1, 6'd8, 1'b1, 64'h8000_0020, 64'h8000_1000);
    vecs[3]  = mk(I_EXT | I_SW, M_EXT | M_SW, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0020, 64'h8000_0024, 1, 6'd11, 1'b0, 64'h8000_0024, 64'h8000_102C);
    vecs[4]  = mk(I_EXT, M_EXT, 1'b0, 2'd3, 64'h8000_1001, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0030, 64'h8000_0034, 0, 6'd0, 1'b0, 64'd0, 64'd0);
    vecs[5]  = mk(I_EXT, M_EXT, 1'b0, 2'd0, 64'h8000_1001, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0030, 64'h8000_0034, 1, 6'd11, 1'b0, 64'h8000_0034, 64'h8000_102C);
    vecs[6]  = mk(3'b000, 64'd0, 1'b1, 2'd3, 64'h8000_1001, 64'h8000_0200, 1'b0, 6'd0, 1'b1,
                  64'h8000_0040, 64'h8000_0044, 2, 6'd0, 1'b0, 64'd0, 64'h8000_0200);
    vecs[7]  = mk(I_SW | I_TMR, M_SW | M_TMR, 1'b1, 2'd3, 64'h8000_2000, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0050, 64'h8000_0054, 1, 6'd3, 1'b0, 64'h8000_0054, 64'h8000_2000);
    vecs[8]  = mk(I_TMR, M_TMR, 1'b1, 2'd3, 64'h8000_1001, 64'h8000_0200, 1'b0, 6'd0, 1'b1,
                  64'h8000_02FC, 64'h8000_0300, 1, 6'd7, 1'b0, 64'h8000_0300, 64'h8000_101C);
    vecs[9]  = mk(3'b000, 64'd0, 1'b1, 2'd3, 64'h8000_1001, 64'h8000_0200, 1'b1, 6'd3, 1'b1,
                  64'h8000_0400, 64'h8000_0404, 1, 6'd3, 1'b1, 64'h8000_0400, 64'h8000_1000);
    vecs[10] = mk(I_TMR, M_EXT | M_SW, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0060, 64'h8000_0064, 0, 6'd0, 1'b0, 64'd0, 64'd0);
    vecs[11] = mk(I_EXT, M_EXT, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0070, 64'h8000_0074, 1, 6'd11, 1'b0, 64'h8000_0074, 64'h0000_0000_0000_001C);
    vecs[12] = mk(I_TMR, M_TMR, 1'b1, 2'd3, 64'h8000_1003, 64'd0, 1'b0, 6'd0, 1'b0,
                  64'h8000_0080, 64'h8000_0084, 1, 6'd7, 1'b0, 64'h8000_0084, 64'h8000_1000);
    vecs[13] = mk(3'b000, 64'd0, 1'b1, 2'd3, 64'h8000_1001, 64'd0, 1'b1, 6'd4, 1'b0,
                  64'h8000_0500, 64'h8000_0504, 1, 6'd4, 1'b1, 64'h8000_0500, 64'h8000_1000);

    rst = 1'b1;
    clear_commit();
    set_irq(3'b000);
    bus.commit_pc = '0; bus.commit_next_pc = '0;
    bus.mie = '0; bus.mstatus_mie = 1'b0; bus.pmode = 2'd3; bus.mtvec = '0; bus.mepc = '0;
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", all_outs(), 64'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Synchronizer latency: commit held with irq raised in the same cycle.
    bus.mie = M_EXT; bus.pmode = 2'd0; bus.mtvec = 64'h8000_1001;
    set_irq(I_EXT);
    bus.commit_valid = 1'b1; bus.commit_next_pc = 64'h8000_0600;
    tick();
    check("sync_edge1", 64'(bus.trap_valid), 64'd0);
    tick();
    check("sync_edge2", 64'(bus.trap_valid), 64'd0);
    tick();
    check("sync_edge3", 64'(bus.trap_valid), 64'd1);
    check("sync_code", 64'(bus.trap_code), 64'd11);
    clear_commit();
    repeat (3) tick();
    set_irq(3'b000);
    repeat (3) tick();

    // Commits during a trap sequence are ignored.
    bus.mtvec = 64'h8000_1001;
    bus.commit_valid = 1'b1; bus.commit_exc_valid = 1'b1; bus.commit_exc_code = 6'd2;
    bus.commit_pc = 64'h8000_0700;
    tick();
    check("busy_trap", 64'(bus.trap_valid), 64'd1);
    bus.commit_exc_code = 6'd5; bus.commit_pc = 64'h8000_0800;
    tick();
    check("busy_wait_code", 64'(bus.trap_code), 64'd2);
    check("busy_wait_pc", bus.trap_pc, 64'h8000_0700);
    tick();
    check("busy_redir", 64'(bus.redirect_valid), 64'd1);
    check("busy_redir_code", 64'(bus.trap_code), 64'd2);
    clear_commit();
    tick();
    check("busy_idle", 64'({bus.trap_valid, bus.stall_commit}), 64'd0);
    tick();
    check("busy_no_retrap", 64'(bus.trap_valid), 64'd0);

    // Pending enabled interrupt without a commit is not taken.
    bus.mie = M_EXT; bus.pmode = 2'd0;
    set_irq(I_EXT);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("no_commit_%0d", i), 64'({bus.trap_valid, bus.stall_commit}), 64'd0);
    end
    set_irq(3'b000);
    repeat (3) tick();

    // Reset asserted while in WAIT.
    bus.commit_valid = 1'b1; bus.commit_exc_valid = 1'b1; bus.commit_exc_code = 6'd6;
    bus.commit_pc = 64'h8000_0900;
    tick();
    clear_commit();
    tick();
    check("rst_in_wait", 64'({bus.stall_commit, bus.trap_valid, bus.redirect_valid}), 64'b100);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", all_outs(), 64'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_after_%0d", i), 64'({bus.redirect_valid, bus.stall_commit, bus.trap_valid}), 64'd0);
    end
    run_vec(vecs[13], "first_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
